// File: rtl/xbox_mac_seq_pkg.sv
//------------------------------------------------------------------------------
// xbox_mac_seq_pkg : shared types and constants for the XBOX vector-MAC sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package xbox_mac_seq_pkg;

  localparam int LINE_W = 256;
  localparam int BE_W   = LINE_W / 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DRAIN    = 3'd2,
    WAIT_MAC = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_e;

  localparam logic [31:0] ST_NONE    = 32'd0;
  localparam logic [31:0] ST_OK      = 32'd1;
  localparam logic [31:0] ST_CFG_ERR = 32'd2;
  localparam logic [31:0] ST_TIMEOUT = 32'd3;

endpackage

`default_nettype wire

// File: rtl/xbox_mac_seq_agen.sv
//------------------------------------------------------------------------------
// xbox_mac_seq_agen : row/line counters and MEM0/MEM1/result line addresses
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xbox_mac_seq_agen #(
  parameter int LOG2_LINES_PER_MEM = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_i,
  input  logic                          line_adv_i,
  input  logic                          row_adv_i,
  input  logic [15:0]                   cfg_num_rows_i,
  input  logic [7:0]                    cfg_row_lines_i,
  input  logic [LOG2_LINES_PER_MEM-1:0] cfg_a_base_i,
  input  logic [LOG2_LINES_PER_MEM-1:0] cfg_b_base_i,
  input  logic [LOG2_LINES_PER_MEM-1:0] cfg_res_base_i,
  output logic [LOG2_LINES_PER_MEM-1:0] a_addr_o,
  output logic [LOG2_LINES_PER_MEM-1:0] b_addr_o,
  output logic [LOG2_LINES_PER_MEM-1:0] res_addr_o,
  output logic [2:0]                    word_sel_o,
  output logic                          last_line_o,
  output logic                          last_row_o
);

  localparam int AW = LOG2_LINES_PER_MEM;

  logic [AW-1:0] a_row_q, a_row_d;
  logic [AW-1:0] b_base_q, b_base_d;
  logic [AW-1:0] res_base_q, res_base_d;
  logic [7:0]    row_lines_q, row_lines_d;
  logic [15:0]   num_rows_q, num_rows_d;
  logic [7:0]    line_q, line_d;
  logic [15:0]   row_q, row_d;

  // a_row_q tracks a_base + r*row_lines incrementally, so no multiplier is needed
  assign a_addr_o    = a_row_q + AW'(line_q);
  assign b_addr_o    = b_base_q + AW'(line_q);
  assign res_addr_o  = res_base_q + AW'(row_q[15:3]);
  assign word_sel_o  = row_q[2:0];
  assign last_line_o = (line_q == row_lines_q - 8'd1);
  assign last_row_o  = (row_q == num_rows_q - 16'd1);

  always_comb begin
    a_row_d     = a_row_q;
    b_base_d    = b_base_q;
    res_base_d  = res_base_q;
    row_lines_d = row_lines_q;
    num_rows_d  = num_rows_q;
    line_d      = line_q;
    row_d       = row_q;
    if (init_i) begin
      a_row_d     = cfg_a_base_i;
      b_base_d    = cfg_b_base_i;
      res_base_d  = cfg_res_base_i;
      row_lines_d = cfg_row_lines_i;
      num_rows_d  = cfg_num_rows_i;
      line_d      = 8'd0;
      row_d       = 16'd0;
    end else begin
      if (line_adv_i) begin
        line_d = last_line_o ? 8'd0 : line_q + 8'd1;
      end
      if (row_adv_i) begin
        row_d   = row_q + 16'd1;
        a_row_d = a_row_q + AW'(row_lines_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_row_q     <= '0;
      b_base_q    <= '0;
      res_base_q  <= '0;
      row_lines_q <= '0;
      num_rows_q  <= '0;
      line_q      <= '0;
      row_q       <= '0;
    end else begin
      a_row_q     <= a_row_d;
      b_base_q    <= b_base_d;
      res_base_q  <= res_base_d;
      row_lines_q <= row_lines_d;
      num_rows_q  <= num_rows_d;
      line_q      <= line_d;
      row_q       <= row_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/xbox_mac_seq.sv
//------------------------------------------------------------------------------
// xbox_mac_seq : streams matrix rows and a shared vector into vec_mac, writes results
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xbox_mac_seq
  import xbox_mac_seq_pkg::*;
#(
  parameter int LOG2_LINES_PER_MEM = 8,
  parameter int MAC_TIMEOUT        = 1024,
  parameter int ACC_W              = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                go,
  input  logic [15:0]                         cfg_num_rows,
  input  logic [7:0]                          cfg_row_lines,
  input  logic [LOG2_LINES_PER_MEM-1:0]       cfg_a_base,
  input  logic [LOG2_LINES_PER_MEM-1:0]       cfg_b_base,
  input  logic [LOG2_LINES_PER_MEM-1:0]       cfg_res_base,
  output logic [1:0][LOG2_LINES_PER_MEM-1:0]  mem_addr,
  output logic [1:0]                          mem_rd,
  input  logic [1:0][LINE_W-1:0]              mem_rdata,
  output logic [1:0]                          mem_wr,
  output logic [1:0][LINE_W-1:0]              mem_wdata,
  output logic [1:0][BE_W-1:0]                mem_be,
  output logic                                mac_start,
  output logic                                mac_vld,
  output logic                                mac_last,
  output logic [LINE_W-1:0]                   mac_a,
  output logic [LINE_W-1:0]                   mac_b,
  input  logic                                mac_done,
  input  logic [ACC_W-1:0]                    mac_result,
  output logic                                busy,
  output logic                                stat_valid,
  output logic [31:0]                         stat_data
);

  localparam int AW = LOG2_LINES_PER_MEM;
  localparam int TW = $clog2(MAC_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [31:0]   code_q, code_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   result_q, result_d;
  logic          start_q, start_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          stat_valid_q, stat_valid_d;
  logic [31:0]   stat_data_q, stat_data_d;

  logic          w_init, w_line_adv, w_row_adv;
  logic [AW-1:0] w_a_addr, w_b_addr, w_res_addr;
  logic [2:0]    w_word_sel;
  logic          w_last_line, w_last_row;

  xbox_mac_seq_agen #(
    .LOG2_LINES_PER_MEM (LOG2_LINES_PER_MEM)
  ) u_agen (
    .clk             (clk),
    .rst             (rst),
    .init_i          (w_init),
    .line_adv_i      (w_line_adv),
    .row_adv_i       (w_row_adv),
    .cfg_num_rows_i  (cfg_num_rows),
    .cfg_row_lines_i (cfg_row_lines),
    .cfg_a_base_i    (cfg_a_base),
    .cfg_b_base_i    (cfg_b_base),
    .cfg_res_base_i  (cfg_res_base),
    .a_addr_o        (w_a_addr),
    .b_addr_o        (w_b_addr),
    .res_addr_o      (w_res_addr),
    .word_sel_o      (w_word_sel),
    .last_line_o     (w_last_line),
    .last_row_o      (w_last_row)
  );

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    tcnt_d       = tcnt_q;
    result_d     = result_q;
    start_d      = 1'b0;
    vld_d        = 1'b0;
    last_d       = 1'b0;
    stat_valid_d = stat_valid_q;
    stat_data_d  = stat_data_q;
    w_init       = 1'b0;
    w_line_adv   = 1'b0;
    w_row_adv    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          w_init       = 1'b1;
          stat_valid_d = 1'b0;
          stat_data_d  = ST_NONE;
          if (cfg_row_lines == 8'd0) begin
            code_d  = ST_CFG_ERR;
            state_d = DONE;
          end else if (cfg_num_rows == 16'd0) begin
            code_d  = ST_OK;
            state_d = DONE;
          end else begin
            start_d = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        w_line_adv = 1'b1;
        vld_d      = 1'b1;
        last_d     = w_last_line;
        if (w_last_line) state_d = DRAIN;
      end
      DRAIN: begin
        tcnt_d  = '0;
        state_d = WAIT_MAC;
      end
      WAIT_MAC: begin
        // mac_done wins over timeout when both land on the same cycle
        if (mac_done) begin
          result_d = 32'(mac_result);
          state_d  = WRITE;
        end else if (tcnt_q == TW'(MAC_TIMEOUT - 1)) begin
          code_d  = ST_TIMEOUT;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (w_last_row) begin
          code_d  = ST_OK;
          state_d = DONE;
        end else begin
          w_row_adv = 1'b1;
          start_d   = 1'b1;
          state_d   = FETCH;
        end
      end
      DONE: begin
        stat_valid_d = 1'b1;
        stat_data_d  = code_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= ST_NONE;
      tcnt_q       <= '0;
      result_q     <= '0;
      start_q      <= 1'b0;
      vld_q        <= 1'b0;
      last_q       <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_data_q  <= ST_NONE;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      tcnt_q       <= tcnt_d;
      result_q     <= result_d;
      start_q      <= start_d;
      vld_q        <= vld_d;
      last_q       <= last_d;
      stat_valid_q <= stat_valid_d;
      stat_data_q  <= stat_data_d;
    end
  end

  assign mem_rd      = (state_q == FETCH) ? 2'b11 : 2'b00;
  assign mem_wr      = {(state_q == WRITE), 1'b0};
  assign mem_addr[0] = (state_q == FETCH) ? w_a_addr : '0;
  assign mem_addr[1] = (state_q == FETCH) ? w_b_addr :
                       (state_q == WRITE) ? w_res_addr : '0;
  assign mem_wdata[0] = '0;
  assign mem_wdata[1] = (state_q == WRITE) ? (LINE_W'(result_q) << {w_word_sel, 5'b0}) : '0;
  assign mem_be[0]    = '0;
  assign mem_be[1]    = (state_q == WRITE) ? (BE_W'(4'hF) << {w_word_sel, 2'b0}) : '0;

  assign mac_start  = start_q;
  assign mac_vld    = vld_q;
  assign mac_last   = last_q;
  assign mac_a      = mem_rdata[0];
  assign mac_b      = mem_rdata[1];
  assign busy       = (state_q != IDLE);
  assign stat_valid = stat_valid_q;
  assign stat_data  = stat_data_q;

endmodule

`default_nettype wire
